m_axi_reg_cmd: RTL

//  Single-beat AXI master that turns simple register commands into AXI write/read transactions.

---
 rtl/m_axi_reg_pkg.sv | 18 +
 rtl/m_axi_reg_cmd.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/m_axi_reg_pkg.sv
// Shared types for the single-beat AXI register master: FSM state encoding
// and the response codes reported on rsp_err.
package m_axi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/m_axi_reg_cmd.sv
// Single-beat AXI master: turns one register command at a time into an AXI
// write (AW+W, then B) or read (AR, then R) and returns status/data on the
// response port. Every AXI valid/ready output is a register, so no output
// depends combinationally on a ready input.
// Optional watchdog: define M_AXI_REG_TIMEOUT_EN to abort a transaction that
// has not completed within TIMEOUT_CYCLES cycles (rsp_err = 11).
module m_axi_reg_cmd
  import m_axi_reg_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 32,
  parameter logic [3:0] ID_VALUE       = 4'd0,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [3:0]              awid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [3:0]              wid_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [3:0]              arid_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [3:0]              rid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    rlast_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [3:0]              bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  state_t state;
  logic   aw_done, w_done;
  logic   aw_fire, w_fire, accept, to_hit;

  assign awid_o  = ID_VALUE;
  assign wid_o   = ID_VALUE;
  assign arid_o  = ID_VALUE;
  assign wlast_o = 1'b1;

  assign accept  = cmd_valid && cmd_ready;
  assign aw_fire = awvalid_o && awready_i;
  assign w_fire  = wvalid_o && wready_i;

  // Single beat only, so rlast carries no information; bresp[0] only
  // distinguishes EXOKAY/DECERR variants we fold into bresp[1].
  logic unused_ok;
  assign unused_ok = ^{rlast_i, bresp_i[0], TIMEOUT_CYCLES[0]};

`ifdef M_AXI_REG_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          in_flight;

  assign in_flight = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);

  // Watchdog: restarts at command accept, counts every in-flight cycle.
  always_ff @(posedge clk) begin
    if (areset)         to_cnt <= '0;
    else if (accept)    to_cnt <= '0;
    else if (in_flight) to_cnt <= to_cnt + 1'b1;
  end

  // A response arriving on the final cycle still wins over the abort.
  assign to_hit = in_flight && (to_cnt == TO_MAX) &&
                  !((state == WR_RESP) && bvalid_i) &&
                  !((state == RD_DATA) && rvalid_i);
`else
  assign to_hit = 1'b0;
`endif

  // Transaction FSM; all handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= RSP_OKAY;
      awaddr_o  <= '0;
      awvalid_o <= 1'b0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      wvalid_o  <= 1'b0;
      araddr_o  <= '0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      bready_o  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cmd_ready <= 1'b0;
          if (cmd_write) begin
            awaddr_o  <= cmd_addr;
            wdata_o   <= cmd_wdata;
            wstrb_o   <= cmd_wstrb;
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= WR_REQ;
          end else begin
            araddr_o  <= cmd_addr;
            arvalid_o <= 1'b1;
            state     <= RD_ADDR;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin awvalid_o <= 1'b0; aw_done <= 1'b1; end
          if (w_fire)  begin wvalid_o  <= 1'b0; w_done  <= 1'b1; end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            bready_o <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: if (bvalid_i) begin
          bready_o  <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= (bresp_i[1] || (bid_i != ID_VALUE)) ? RSP_SLVERR : RSP_OKAY;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RD_ADDR: if (arready_i) begin
          arvalid_o <= 1'b0;
          rready_o  <= 1'b1;
          state     <= RD_DATA;
        end
        RD_DATA: if (rvalid_i) begin
          rready_o  <= 1'b0;
          rsp_rdata <= rdata_i;
          rsp_err   <= (rid_i != ID_VALUE) ? RSP_SLVERR : RSP_OKAY;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (to_hit) begin
        awvalid_o <= 1'b0;
        wvalid_o  <= 1'b0;
        arvalid_o <= 1'b0;
        rready_o  <= 1'b0;
        bready_o  <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= RSP_TIMEOUT;
        rsp_valid <= 1'b1;
        state     <= RSP;
      end
    end
  end

endmodule
